// File: rtl/mdio_responder_if.sv
// MDIO pin bundle between a station-management master and the PHY-side responder.
// The master owns MDC and the resolved MDIO line; the responder drives MDIO through mdio_oe.
interface mdio_responder_if;
    logic mdc_in;
    logic mdio_in;
    logic mdio_out;
    logic mdio_oe;

    modport slave (
        input  mdc_in,
        input  mdio_in,
        output mdio_out,
        output mdio_oe
    );

    modport master (
        output mdc_in,
        output mdio_in,
        input  mdio_out,
        input  mdio_oe
    );
endinterface

// File: rtl/mdio_responder.sv
// Clause-22 MDIO target modelled on the KSZ9021/KSZ9031 management port.
// MDC/MDIO are oversampled on clock; frames are decoded into a 32x16 register file.
module mdio_responder #(
    parameter logic [4:0]  PHY_ADDR     = 5'h00,
    parameter logic [15:0] ID1          = 16'h0022,
    parameter logic [15:0] ID2          = 16'h1611,
    parameter logic [15:0] CTRL_DEFAULT = 16'h1140,
    parameter int unsigned PRE_LEN      = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    mdio_responder_if.slave        mdio,
    input  logic [15:0]            status_in,
    input  logic [15:0]            phyctl_in,
    input  logic [15:0]            ext_rd_data,
    output logic                   ext_wr,
    output logic                   ext_rd,
    output logic [8:0]             ext_addr,
    output logic [15:0]            ext_wr_data,
    output logic                   reg_wr,
    output logic [4:0]             reg_addr,
    output logic [15:0]            reg_wr_data,
    output logic                   frame_err
);
    localparam int unsigned     CntW   = $clog2(PRE_LEN + 1);
    localparam logic [CntW-1:0] PreMax = CntW'(PRE_LEN);

    typedef enum logic [3:0] {
        StPre, StSt, StOp, StPhy, StReg, StRdTa, StRdData, StRdEnd, StWrTa, StWrData
    } state_e;

    state_e          r_state;
    logic            r_mdc_s1, r_mdc_s2, r_mdc_d, r_mdio_s1, r_mdio_s2;
    logic [CntW-1:0] r_pre_cnt;
    logic [3:0]      r_bit_cnt;
    logic [14:0]     r_shift;
    logic            r_is_read;
    logic [4:0]      r_regad;
    logic [15:0]     r_rd_word;
    logic [15:0]     r_regs [32];
    logic            r_oe, r_out;
    logic            r_reg_wr, r_ext_wr, r_ext_rd, r_frame_err;
    logic [4:0]      r_reg_addr;
    logic [15:0]     r_reg_wr_data, r_ext_wr_data;

    logic            w_rise, w_fall, w_bit, w_ro;
    logic [15:0]     w_shift_in, w_rd_mux;

    assign w_rise     = r_mdc_s2 & ~r_mdc_d;
    assign w_fall     = ~r_mdc_s2 & r_mdc_d;
    assign w_bit      = r_mdio_s2;
    assign w_shift_in = {r_shift, w_bit};
    assign w_ro       = (r_regad == 5'h01) || (r_regad == 5'h02) || (r_regad == 5'h03) ||
                        (r_regad == 5'h1F);

    // Read word selected by the REGAD field that completes on this rise.
    always_comb begin
        w_rd_mux = r_regs[w_shift_in[4:0]];
        unique case (w_shift_in[4:0])
            5'h00:   w_rd_mux = {1'b0, r_regs[0][14:0]};
            5'h01:   w_rd_mux = status_in;
            5'h02:   w_rd_mux = ID1;
            5'h03:   w_rd_mux = ID2;
            5'h0D:   w_rd_mux = ext_rd_data;
            5'h1F:   w_rd_mux = phyctl_in;
            default: w_rd_mux = r_regs[w_shift_in[4:0]];
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_mdc_s1      <= 1'b0;
            r_mdc_s2      <= 1'b0;
            r_mdc_d       <= 1'b0;
            r_mdio_s1     <= 1'b0;
            r_mdio_s2     <= 1'b0;
            r_state       <= StPre;
            r_pre_cnt     <= '0;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_is_read     <= 1'b0;
            r_regad       <= '0;
            r_rd_word     <= '0;
            r_oe          <= 1'b0;
            r_out         <= 1'b0;
            r_reg_wr      <= 1'b0;
            r_ext_wr      <= 1'b0;
            r_ext_rd      <= 1'b0;
            r_frame_err   <= 1'b0;
            r_reg_addr    <= '0;
            r_reg_wr_data <= '0;
            r_ext_wr_data <= '0;
            for (int i = 0; i < 32; i++) r_regs[i] <= (i == 0) ? CTRL_DEFAULT : 16'h0000;
        end else begin
            r_mdc_s1    <= mdio.mdc_in;
            r_mdc_s2    <= r_mdc_s1;
            r_mdc_d     <= r_mdc_s2;
            r_mdio_s1   <= mdio.mdio_in;
            r_mdio_s2   <= r_mdio_s1;
            r_reg_wr    <= 1'b0;
            r_ext_wr    <= 1'b0;
            r_ext_rd    <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_rise) r_shift <= w_shift_in[14:0];

            unique case (r_state)
                StPre: if (w_rise) begin
                    if (w_bit) begin
                        if (r_pre_cnt != PreMax) r_pre_cnt <= r_pre_cnt + 1'b1;
                    end else begin
                        // This 0 is the first ST bit once enough preamble has been seen.
                        r_pre_cnt <= '0;
                        if (r_pre_cnt == PreMax) r_state <= StSt;
                    end
                end
                StSt: if (w_rise) begin
                    r_bit_cnt <= '0;
                    if (w_bit) begin
                        r_state <= StOp;
                    end else begin
                        r_frame_err <= 1'b1;
                        r_state     <= StPre;
                    end
                end
                StOp: if (w_rise) begin
                    if (r_bit_cnt == 4'd0) begin
                        r_bit_cnt <= 4'd1;
                    end else begin
                        r_bit_cnt <= '0;
                        r_is_read <= (w_shift_in[1:0] == 2'b10);
                        if (w_shift_in[1] != w_shift_in[0]) begin
                            r_state <= StPhy;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= StPre;
                        end
                    end
                end
                StPhy: if (w_rise) begin
                    if (r_bit_cnt != 4'd4) begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end else begin
                        r_bit_cnt <= '0;
                        if (w_shift_in[4:0] == PHY_ADDR) r_state <= StReg;
                        else r_state <= StPre;
                    end
                end
                StReg: if (w_rise) begin
                    if (r_bit_cnt != 4'd4) begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end else begin
                        r_bit_cnt <= '0;
                        r_regad   <= w_shift_in[4:0];
                        r_rd_word <= w_rd_mux;
                        if (r_is_read) r_state <= StRdTa;
                        else r_state <= StWrTa;
                    end
                end
                StRdTa: if (w_rise) begin
                    r_oe    <= 1'b1;
                    r_out   <= 1'b0;
                    r_state <= StRdData;
                end
                StRdData: if (w_rise) begin
                    r_out     <= r_rd_word[15];
                    r_rd_word <= {r_rd_word[14:0], 1'b0};
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                    if (r_bit_cnt == 4'd15) r_state <= StRdEnd;
                end
                StRdEnd: if (w_fall) begin
                    r_oe    <= 1'b0;
                    r_out   <= 1'b0;
                    r_state <= StPre;
                end
                StWrTa: if (w_rise) begin
                    if (r_bit_cnt == 4'd0 && w_bit) begin
                        r_bit_cnt <= 4'd1;
                    end else if (r_bit_cnt != 4'd0 && !w_bit) begin
                        r_bit_cnt <= '0;
                        r_state   <= StWrData;
                    end else begin
                        r_bit_cnt   <= '0;
                        r_frame_err <= 1'b1;
                        r_state     <= StPre;
                    end
                end
                StWrData: if (w_rise) begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                    if (r_bit_cnt == 4'd15) begin
                        r_state       <= StPre;
                        r_reg_wr      <= 1'b1;
                        r_reg_addr    <= r_regad;
                        r_reg_wr_data <= w_shift_in;
                        if (r_regad == 5'h00 && w_shift_in[15]) begin
                            for (int i = 0; i < 32; i++) begin
                                r_regs[i] <= (i == 0) ? CTRL_DEFAULT : 16'h0000;
                            end
                        end else if (!w_ro) begin
                            r_regs[r_regad] <= w_shift_in;
                            if (r_regad == 5'h0B && !w_shift_in[15]) r_ext_rd <= 1'b1;
                            if (r_regad == 5'h0C && r_regs[11][15]) begin
                                r_ext_wr      <= 1'b1;
                                r_ext_wr_data <= w_shift_in;
                            end
                        end
                    end
                end
                default: r_state <= StPre;
            endcase
        end
    end

    assign mdio.mdio_oe  = r_oe;
    assign mdio.mdio_out = r_out;
    assign ext_wr        = r_ext_wr;
    assign ext_rd        = r_ext_rd;
    assign ext_addr      = r_regs[11][8:0];
    assign ext_wr_data   = r_ext_wr_data;
    assign reg_wr        = r_reg_wr;
    assign reg_addr      = r_reg_addr;
    assign reg_wr_data   = r_reg_wr_data;
    assign frame_err     = r_frame_err;
endmodule

// File: tb/tb_mdio_responder.sv
// Bench for mdio_responder: a bit-level MDIO master plus a register-map reference model.
// The master sets MDIO while MDC is low and samples the line late in the MDC high phase.
module tb_mdio_responder;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] status_in   = 16'h796D;
    logic [15:0] phyctl_in   = 16'h0068;
    logic [15:0] ext_rd_data = 16'hBEEF;
    logic        ext_wr, ext_rd, reg_wr, frame_err;
    logic [8:0]  ext_addr;
    logic [15:0] ext_wr_data, reg_wr_data;
    logic [4:0]  reg_addr;
    logic        mst_oe  = 1'b0;
    logic        mst_val = 1'b1;

    always #5 clock = ~clock;

    mdio_responder_if bus ();
    // Pulled-up open line: responder, else master, else 1.
    assign bus.mdio_in = bus.mdio_oe ? bus.mdio_out : (mst_oe ? mst_val : 1'b1);

    mdio_responder dut (
        .clock       (clock),
        .reset       (reset),
        .mdio        (bus),
        .status_in   (status_in),
        .phyctl_in   (phyctl_in),
        .ext_rd_data (ext_rd_data),
        .ext_wr      (ext_wr),
        .ext_rd      (ext_rd),
        .ext_addr    (ext_addr),
        .ext_wr_data (ext_wr_data),
        .reg_wr      (reg_wr),
        .reg_addr    (reg_addr),
        .reg_wr_data (reg_wr_data),
        .frame_err   (frame_err)
    );

    int n_reg_wr = 0, n_ext_wr = 0, n_ext_rd = 0, n_ferr = 0, n_oe = 0, n_clash = 0, n_zdrive = 0;
    always @(negedge clock) begin
        if (reg_wr) n_reg_wr++;
        if (ext_wr) n_ext_wr++;
        if (ext_rd) n_ext_rd++;
        if (frame_err) n_ferr++;
        if (bus.mdio_oe) n_oe++;
        if (bus.mdio_oe && mst_oe) n_clash++;
        if (!bus.mdio_oe && bus.mdio_out) n_zdrive++;
    end

    int checks = 0;
    int errors = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model of the register map.
    logic [15:0] m_regs [32];
    int          m_reg_wr = 0, m_ext_wr = 0, m_ext_rd = 0;
    logic [15:0] m_ext_data = 16'h0000;

    function automatic void model_defaults();
        for (int i = 0; i < 32; i++) m_regs[i] = 16'h0000;
        m_regs[0] = 16'h1140;
    endfunction

    function automatic logic [15:0] model_read(input logic [4:0] a);
        case (a)
            5'h00:   return m_regs[0] & 16'h7FFF;
            5'h01:   return status_in;
            5'h02:   return 16'h0022;
            5'h03:   return 16'h1611;
            5'h0D:   return ext_rd_data;
            5'h1F:   return phyctl_in;
            default: return m_regs[a];
        endcase
    endfunction

    function automatic void model_write(input logic [4:0] a, input logic [15:0] d);
        m_reg_wr++;
        if (a == 5'h00 && d[15]) begin
            model_defaults();
        end else if (!(a inside {5'h01, 5'h02, 5'h03, 5'h1F})) begin
            if (a == 5'h0C && m_regs[11][15]) begin
                m_ext_wr++;
                m_ext_data = d;
            end
            if (a == 5'h0B && !d[15]) m_ext_rd++;
            m_regs[a] = d;
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic slot(input logic drive, input logic b, output logic s);
        mst_oe  = drive;
        mst_val = b;
        tick(4);
        bus.mdc_in = 1'b1;
        tick(4);
        s = bus.mdio_in;
        tick(1);
        bus.mdc_in = 1'b0;
    endtask

    // rx[16] is the turnaround bit, rx[15:0] the read word (read frames only).
    task automatic frame(input int npre, input logic [1:0] st, input logic [1:0] op,
                         input logic [4:0] phy, input logic [4:0] ra, input logic [1:0] ta,
                         input logic [15:0] wd, output logic [16:0] rx);
        logic        s;
        logic [13:0] h;
        rx = '0;
        h  = {st, op, phy, ra};
        for (int i = 0; i < npre; i++) slot(1'b1, 1'b1, s);
        for (int i = 13; i >= 0; i--) slot(1'b1, h[i], s);
        if (op == 2'b10) begin
            for (int i = 16; i >= 0; i--) begin
                slot(1'b0, 1'b1, s);
                rx[i] = s;
            end
        end else begin
            slot(1'b1, ta[1], s);
            slot(1'b1, ta[0], s);
            for (int i = 15; i >= 0; i--) slot(1'b1, wd[i], s);
        end
        mst_oe = 1'b0;
        tick(6);
    endtask

    task automatic do_write(input logic [4:0] ra, input logic [15:0] d);
        logic [16:0] rx;
        frame(32, 2'b01, 2'b01, 5'h00, ra, 2'b10, d, rx);
        model_write(ra, d);
        check("reg_wr_count", n_reg_wr, m_reg_wr);
        check("reg_addr", reg_addr, ra);
        check("reg_wr_data", reg_wr_data, d);
        check("ext_wr_count", n_ext_wr, m_ext_wr);
        check("ext_rd_count", n_ext_rd, m_ext_rd);
        check("ext_addr", ext_addr, m_regs[11][8:0]);
        check("ext_wr_data", ext_wr_data, m_ext_data);
    endtask

    task automatic do_read(input logic [4:0] ra, output logic [15:0] data);
        logic [16:0] rx;
        frame(32, 2'b01, 2'b10, 5'h00, ra, 2'b00, 16'h0000, rx);
        check("read_ta2", rx[16], 1'b0);
        check("oe_after_read", bus.mdio_oe, 1'b0);
        data = rx[15:0];
    endtask

    typedef struct {
        logic        wr;
        logic [4:0]  ra;
        logic [15:0] d;
        logic [15:0] exp;
    } vec_t;

    initial begin
        vec_t        tbl [15];
        logic [15:0] rd;
        logic [16:0] rx;
        logic        s;
        logic [13:0] h;
        int          base_wr, base_ferr, base_ext;

        bus.mdc_in = 1'b0;
        model_defaults();
        tick(5);
        check("reset_oe_out", {bus.mdio_oe, bus.mdio_out}, 2'b00);
        check("reset_pulses", {reg_wr, ext_wr, ext_rd, frame_err}, 4'b0000);
        check("reset_regs", {reg_addr, reg_wr_data, ext_addr, ext_wr_data}, 46'h0);
        reset = 1'b0;
        tick(3);

        tbl[0]  = '{1'b0, 5'h03, 16'h0000, 16'h1611};
        tbl[1]  = '{1'b0, 5'h00, 16'h0000, 16'h1140};
        tbl[2]  = '{1'b0, 5'h01, 16'h0000, 16'h796D};
        tbl[3]  = '{1'b0, 5'h02, 16'h0000, 16'h0022};
        tbl[4]  = '{1'b0, 5'h1F, 16'h0000, 16'h0068};
        tbl[5]  = '{1'b0, 5'h0D, 16'h0000, 16'hBEEF};
        tbl[6]  = '{1'b0, 5'h09, 16'h0000, 16'h0000};
        tbl[7]  = '{1'b1, 5'h09, 16'h0200, 16'h0000};
        tbl[8]  = '{1'b0, 5'h09, 16'h0000, 16'h0200};
        tbl[9]  = '{1'b1, 5'h02, 16'hFFFF, 16'h0000};
        tbl[10] = '{1'b0, 5'h02, 16'h0000, 16'h0022};
        tbl[11] = '{1'b1, 5'h00, 16'h1300, 16'h0000};
        tbl[12] = '{1'b0, 5'h00, 16'h0000, 16'h1300};
        tbl[13] = '{1'b1, 5'h00, 16'h9300, 16'h0000};
        tbl[14] = '{1'b0, 5'h09, 16'h0000, 16'h0000};
        for (int i = 0; i < 15; i++) begin
            if (tbl[i].wr) begin
                do_write(tbl[i].ra, tbl[i].d);
            end else begin
                do_read(tbl[i].ra, rd);
                check("table_read", rd, tbl[i].exp);
            end
        end
        do_read(5'h00, rd);
        check("ctrl_after_soft_reset", rd, 16'h1140);

        // Extended-register window.
        base_ext = n_ext_wr;
        do_write(5'h0B, 16'h8104);
        do_write(5'h0C, 16'hC277);
        check("ext_wr_once", n_ext_wr - base_ext, 1);
        check("ext_addr_104", ext_addr, 9'h104);
        check("ext_data_c277", ext_wr_data, 16'hC277);
        do_read(5'h0C, rd);
        check("reg0c_readback", rd, 16'hC277);
        base_ext = n_ext_rd;
        do_write(5'h0B, 16'h0055);
        check("ext_rd_once", n_ext_rd - base_ext, 1);

        // Foreign PHYAD: no drive, no strobes, then normal service.
        base_wr   = n_reg_wr;
        base_ferr = n_ferr;
        n_oe      = 0;
        frame(32, 2'b01, 2'b10, 5'h05, 5'h03, 2'b00, 16'h0000, rx);
        frame(32, 2'b01, 2'b01, 5'h05, 5'h09, 2'b10, 16'hAAAA, rx);
        check("phyad5_oe", n_oe, 0);
        check("phyad5_wr", n_reg_wr - base_wr, 0);
        check("phyad5_err", n_ferr - base_ferr, 0);
        do_read(5'h03, rd);
        check("after_phyad5", rd, 16'h1611);

        // Short preamble is ignored; bad OP, ST and write TA each flag once.
        frame(31, 2'b01, 2'b01, 5'h00, 5'h0A, 2'b10, 16'h1234, rx);
        check("short_pre_wr", n_reg_wr - base_wr, 0);
        frame(32, 2'b01, 2'b11, 5'h00, 5'h0A, 2'b10, 16'h1234, rx);
        check("bad_op_err", n_ferr - base_ferr, 1);
        frame(32, 2'b00, 2'b01, 5'h00, 5'h0A, 2'b10, 16'h1234, rx);
        check("bad_st_err", n_ferr - base_ferr, 2);
        frame(32, 2'b01, 2'b01, 5'h00, 5'h0A, 2'b11, 16'h1234, rx);
        check("bad_ta_err", n_ferr - base_ferr, 3);
        check("bad_frames_wr", n_reg_wr - base_wr, 0);
        do_read(5'h0A, rd);
        check("reg0a_untouched", rd, 16'h0000);

        // Randomized traffic against the model.
        for (int i = 0; i < 30; i++) begin
            logic [4:0]  a;
            logic [15:0] d;
            a           = 5'($urandom_range(0, 31));
            d           = 16'($urandom);
            status_in   = 16'($urandom);
            phyctl_in   = 16'($urandom);
            ext_rd_data = 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                if (a == 5'h00 && $urandom_range(0, 3) != 0) d[15] = 1'b0;
                do_write(a, d);
            end else begin
                do_read(a, rd);
                check("rnd_read", rd, model_read(a));
            end
        end

        // Reset in the middle of a read data phase.
        do_write(5'h09, 16'h5A5A);
        h = {2'b01, 2'b10, 5'h00, 5'h09};
        for (int i = 0; i < 32; i++) slot(1'b1, 1'b1, s);
        for (int i = 13; i >= 0; i--) slot(1'b1, h[i], s);
        for (int i = 0; i < 6; i++) slot(1'b0, 1'b1, s);
        check("oe_mid_read", bus.mdio_oe, 1'b1);
        reset = 1'b1;
        tick(1);
        check("oe_after_reset", bus.mdio_oe, 1'b0);
        reset = 1'b0;
        model_defaults();
        m_ext_data = 16'h0000;
        tick(3);
        do_read(5'h09, rd);
        check("reg09_after_reset", rd, 16'h0000);
        do_read(5'h03, rd);
        check("id2_after_reset", rd, 16'h1611);

        check("no_contention", n_clash, 0);
        check("out_zero_when_released", n_zdrive, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
